// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the fetch PC, issues to a one-cycle synchronous imem,
// and queues returned words in a 2-entry FIFO (output slot + skid) presented to decode.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [63:0] id_pc,
  output logic [31:0] id_inst
);

  logic [63:0] pc_q, pc_n;
  logic        infl_v, infl_v_n;
  logic [63:0] infl_pc, infl_pc_n;
  logic        out_v, out_v_n;
  logic [63:0] out_pc, out_pc_n;
  logic [31:0] out_inst, out_inst_n;
  logic        skid_v, skid_v_n;
  logic [63:0] skid_pc, skid_pc_n;
  logic [31:0] skid_inst, skid_inst_n;

  logic       fire;
  logic [1:0] occ;
  logic       unused_ok;

  // Redirect targets are word aligned; the low bits are dropped on purpose.
  assign unused_ok = ^redirect_pc[1:0];

  assign fire      = out_v & id_ready;
  assign occ       = {1'b0, out_v} + {1'b0, skid_v} + {1'b0, infl_v};
  assign imem_req  = !reset && !redirect_valid && ((occ - {1'b0, fire}) <= 2'd1);
  assign imem_addr = pc_q;

  assign id_valid = out_v;
  assign id_pc    = out_pc;
  assign id_inst  = out_inst;

  always_comb begin
    pc_n        = pc_q;
    infl_v_n    = 1'b0;
    infl_pc_n   = infl_pc;
    out_v_n     = out_v;
    out_pc_n    = out_pc;
    out_inst_n  = out_inst;
    skid_v_n    = skid_v;
    skid_pc_n   = skid_pc;
    skid_inst_n = skid_inst;

    if (fire) begin
      out_v_n  = skid_v;
      skid_v_n = 1'b0;
      if (skid_v) begin
        out_pc_n   = skid_pc;
        out_inst_n = skid_inst;
      end
    end

    // Returning word fills the first free slot after the dequeue shift.
    if (infl_v) begin
      if (!out_v_n) begin
        out_v_n    = 1'b1;
        out_pc_n   = infl_pc;
        out_inst_n = imem_inst;
      end else if (!skid_v_n) begin
        skid_v_n    = 1'b1;
        skid_pc_n   = infl_pc;
        skid_inst_n = imem_inst;
      end
    end

    if (imem_req) begin
      infl_v_n  = 1'b1;
      infl_pc_n = pc_q;
      pc_n      = pc_q + 64'd4;
    end

    if (redirect_valid) begin
      out_v_n  = 1'b0;
      skid_v_n = 1'b0;
      infl_v_n = 1'b0;
      pc_n     = {redirect_pc[63:2], 2'b00};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      infl_v    <= 1'b0;
      infl_pc   <= 64'h0;
      out_v     <= 1'b0;
      out_pc    <= 64'h0;
      out_inst  <= 32'h0;
      skid_v    <= 1'b0;
      skid_pc   <= 64'h0;
      skid_inst <= 32'h0;
    end else begin
      pc_q      <= pc_n;
      infl_v    <= infl_v_n;
      infl_pc   <= infl_pc_n;
      out_v     <= out_v_n;
      out_pc    <= out_pc_n;
      out_inst  <= out_inst_n;
      skid_v    <= skid_v_n;
      skid_pc   <= skid_pc_n;
      skid_inst <= skid_inst_n;
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the RV64 core. Owns the fetch program counter, issues byte addresses to the synchronous-read instruction memory (one-cycle read latency), and captures the returned words into a 2-entry holding queue. It presents `{pc, instruction}` pairs to decode over a valid/ready handshake. Execute-stage branch redirects flush all queued and in-flight fetches.

## Interface
- `RESET_PC`, default 64'h0: fetch address loaded on reset.
- `clk`  in  1: clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-high.
- `imem_req`  out  1: a fetch is issued this cycle; combinational.
- `imem_addr`  out  64: byte address of the fetch; equals `pc_q`; combinational.
- `imem_inst`  in  32: instruction word for the fetch issued in the previous cycle.
- `redirect_valid`  in  1: branch taken; flush and refetch from `redirect_pc`.
- `redirect_pc`  in  64: redirect target; bits [1:0] ignored (treated as 0).
- `id_valid`  out  1: `id_pc`/`id_inst` hold a valid fetched instruction.
- `id_ready`  in  1: decode accepts this cycle.
- `id_pc`  out  64: PC of the presented instruction.
- `id_inst`  out  32: presented instruction word.

## Operation
- State: `pc_q` (next fetch PC); `infl_v`/`infl_pc` (fetch issued last cycle); output slot `out_v/out_pc/out_inst` driving `id_*`; skid slot `skid_v/skid_pc/skid_inst`.
- `fire = id_valid & id_ready`. `occ = out_v + skid_v + infl_v`.
- Issue rule: `imem_req = !redirect_valid && (occ - fire) <= 1`. On issue: `infl_v<=1`, `infl_pc<=pc_q`, `pc_q<=pc_q+4`, modulo 2^64 (wraps from 0xFFFF_FFFF_FFFF_FFFC to 0).
- Return: when `infl_v`=1, `imem_inst` is sampled with `infl_pc` into the queue.
- Queue order is FIFO: output slot first, then skid. After `fire`, the skid entry, if present, moves into the output slot. A returning fetch fills the first free slot in that order. The issue rule guarantees no overflow. If one occurs, it is a design error; the bench asserts on it.
- Redirect, which has priority over everything:
  - `out_v`, `skid_v` and `infl_v` clear next cycle, and the in-flight return is discarded.
  - `pc_q <= {redirect_pc[63:2],2'b00}`.
  - No issue occurs in the redirect cycle.
  - A `fire` in the same cycle counts as accepted by decode.
- `id_pc`/`id_inst` hold their value while `id_valid`=1 and `id_ready`=0. Data is don't-care when `id_valid`=0, but the registers keep their last value.
- Reset values: `pc_q`=RESET_PC; all valid bits 0; `id_valid`=0; `id_pc`=0; `id_inst`=0; `imem_req`=0 while `reset` is asserted; `imem_addr`=RESET_PC.

## Timing
- Fetch issued in cycle N → `imem_inst` valid in N+1 → `id_valid` asserted in N+2 at the earliest.
- After `reset` deasserts, the first `imem_req` is in cycle 0, and the first `id_valid` (`id_pc`=RESET_PC) is in cycle 2.
- With `id_ready` held at 1, throughput is one instruction per cycle with no bubbles.
- During stall (`id_ready`=0): at most two words are queued plus none in flight. `imem_req` drops once `occ`=2. After `id_ready` returns, issue resumes in the same cycle.
- Redirect in cycle R: `id_valid`=0 in R+1. The fetch at the target issues in R+1, and the target is presented in R+3. Redirect penalty is 2 bubbles beyond the flushed entries.
- Back-to-back redirects: the latest one wins. Each redirect restarts the 2-cycle latency.
- Asynchronous reset mid-operation: all state returns to reset values immediately. Any return pending on `imem_inst` is ignored.

## Test plan
- Streaming: RESET_PC=0, memory word k = 0x1000_0000+k, `id_ready`=1. Expect `id_pc` = 0,4,8,… on consecutive cycles starting at cycle 2, with `id_inst` matching.
- Backpressure: after 3 accepts, hold `id_ready`=0 for 6 cycles. Expect `id_pc`=0xC to be held stable and `imem_req` to be 0 once two entries are queued. On release, expect 0xC,0x10,0x14,… with no gap, duplicate or drop.
- Redirect mid-stream: `redirect_valid`=1 with `redirect_pc`=0x103 while one fetch is in flight and two entries are queued. Expect `id_valid`=0 for 2 cycles, then `id_pc`=0x100, 0x104. No pre-redirect PC may appear.
- Simultaneous events: redirect to 0x200 in the same cycle as `fire` of pc 0x40, then a second redirect to 0x300 one cycle later. Expect 0x40 counted as consumed, no 0x200 presented, and the first valid output to be pc 0x300.
- Wrap: RESET_PC=0xFFFF_FFFF_FFFF_FFF8. Expect `id_pc` sequence …FFF8, …FFFC, 0x0, 0x4.
- Reset mid-stall: assert `reset` asynchronously between clock edges with the queue full. Expect `id_valid`=0 immediately and `imem_addr`=RESET_PC. After release, streaming restarts exactly as in the first scenario.
